// File: rtl/nios2_mul_pkg.sv
// Shared encodings for the Nios II pipelined multiplier.
// Optional high-word support is selected by the NIOS2_MUL_HIGH_EN macro.
package nios2_mul_pkg;

   typedef logic [1:0] mul_op_t;

   localparam mul_op_t MUL_OP_MUL    = 2'd0;
   localparam mul_op_t MUL_OP_MULXSS = 2'd1;
   localparam mul_op_t MUL_OP_MULXSU = 2'd2;
   localparam mul_op_t MUL_OP_MULXUU = 2'd3;

   localparam int unsigned LAT_MIN = 2;
   localparam int unsigned LAT_MAX = 3;

endpackage

// File: rtl/nios2_mul_pp.sv
// One unsigned HxH partial-product multiplier with registered output.
// Intended to map onto a single DSP block; carries no sign handling.
module nios2_mul_pp
   import nios2_mul_pkg::*;
#(
   parameter int unsigned H = 16
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           en,
   input  logic [H-1:0]   a,
   input  logic [H-1:0]   b,
   output logic [2*H-1:0] p
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         p <= '0;
      end else if (en) begin
         p <= {{H{1'b0}}, a} * {{H{1'b0}}, b};
      end
   end

endmodule

// File: rtl/nios2_mul_pipe.sv
// Pipelined Nios II multiplier: MUL low word and, with NIOS2_MUL_HIGH_EN defined,
// MULXSS/MULXSU/MULXUU high words. LAT counts pipeline registers (2 or 3).
module nios2_mul_pipe
   import nios2_mul_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned LAT    = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   input  mul_op_t           in_op,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic              stall,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_result,
   output logic              busy
);

   localparam int unsigned H = DATA_W / 2;

   logic              adv;
   logic              s0_valid;
   logic              s0_held;
   mul_op_t           s0_op;
   logic [DATA_W-1:0] s0_a;
   logic [DATA_W-1:0] s0_b;

   assign adv = !stall;

   if (LAT == LAT_MAX) begin : g_in_reg
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            s0_valid <= 1'b0;
            s0_op    <= MUL_OP_MUL;
            s0_a     <= '0;
            s0_b     <= '0;
         end else if (adv) begin
            s0_valid <= in_valid;
            s0_op    <= in_op;
            s0_a     <= in_a;
            s0_b     <= in_b;
         end
      end
      assign s0_held = s0_valid;
   end else begin : g_in_pass
      assign s0_valid = in_valid;
      assign s0_op    = in_op;
      assign s0_a     = in_a;
      assign s0_b     = in_b;
      assign s0_held  = 1'b0;
   end

   // Stage P: partial products plus the op/valid tags that travel with them.
   logic              p_valid;
   mul_op_t           p_op;
   logic [DATA_W-1:0] p1, p2, p3;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         p_valid <= 1'b0;
         p_op    <= MUL_OP_MUL;
      end else if (adv) begin
         p_valid <= s0_valid;
         p_op    <= s0_op;
      end
   end

   nios2_mul_pp #(.H(H)) u_pp1 (
      .clk(clk), .reset_n(reset_n), .en(adv),
      .a(s0_a[H-1:0]), .b(s0_b[H-1:0]), .p(p1)
   );
   nios2_mul_pp #(.H(H)) u_pp2 (
      .clk(clk), .reset_n(reset_n), .en(adv),
      .a(s0_a[H-1:0]), .b(s0_b[DATA_W-1:H]), .p(p2)
   );
   nios2_mul_pp #(.H(H)) u_pp3 (
      .clk(clk), .reset_n(reset_n), .en(adv),
      .a(s0_a[DATA_W-1:H]), .b(s0_b[H-1:0]), .p(p3)
   );

   logic [DATA_W:0]   mid;
   logic [DATA_W-1:0] lo_word;
   logic [DATA_W-1:0] hi_word;
   logic [DATA_W-1:0] result;

   assign mid = {1'b0, p2} + {1'b0, p3};

`ifdef NIOS2_MUL_HIGH_EN
   logic [DATA_W-1:0]   p4;
   logic [DATA_W-1:0]   p_a;
   logic [DATA_W-1:0]   p_b;
   logic [2*DATA_W-1:0] full;
   logic [DATA_W-1:0]   corr_a;
   logic [DATA_W-1:0]   corr_b;

   nios2_mul_pp #(.H(H)) u_pp4 (
      .clk(clk), .reset_n(reset_n), .en(adv),
      .a(s0_a[DATA_W-1:H]), .b(s0_b[DATA_W-1:H]), .p(p4)
   );

   // Raw operands ride along for the two's-complement high-word correction.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         p_a <= '0;
         p_b <= '0;
      end else if (adv) begin
         p_a <= s0_a;
         p_b <= s0_b;
      end
   end

   always_comb begin
      full    = {{DATA_W{1'b0}}, p1} + ({{(DATA_W-1){1'b0}}, mid} << H) + {p4, {DATA_W{1'b0}}};
      lo_word = full[DATA_W-1:0];
      corr_a  = (p_a[DATA_W-1] && (p_op == MUL_OP_MULXSS || p_op == MUL_OP_MULXSU)) ? p_b : '0;
      corr_b  = (p_b[DATA_W-1] && p_op == MUL_OP_MULXSS) ? p_a : '0;
      hi_word = full[2*DATA_W-1:DATA_W] - corr_a - corr_b;
   end
`else
   always_comb begin
      lo_word = p1 + DATA_W'(mid << H);
      hi_word = '0;
   end
`endif

   assign result = (p_op == MUL_OP_MUL) ? lo_word : hi_word;

   // Stage S: result only reloads on a valid op so it stays put between pulses.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid  <= 1'b0;
         out_result <= '0;
      end else if (adv) begin
         out_valid <= p_valid;
         if (p_valid) begin
            out_result <= result;
         end
      end
   end

   assign busy = s0_held | p_valid | out_valid;

endmodule

// File: tb/tb_nios2_mul_pipe.sv
// Scoreboard bench driving a LAT=2 and a LAT=3 instance with identical stimulus.
module tb_nios2_mul_pipe;
   import nios2_mul_pkg::*;

   localparam int unsigned L2 = 2;
   localparam int unsigned L3 = 3;
`ifdef NIOS2_MUL_HIGH_EN
   localparam bit HIGH = 1'b1;
`else
   localparam bit HIGH = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] val;
      int unsigned due;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        stall = 1'b0;
   mul_op_t     in_op = MUL_OP_MUL;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic [31:0] cur_exp = '0;

   logic        ov2, busy2, ov3, busy3;
   logic [31:0] res2, res3;

   exp_t        q2[$];
   exp_t        q3[$];
   exp_t        e2, e3;
   int unsigned nse = 0;
   bit          last_stalled = 1'b0;
   bit          held_v2 = 1'b0, held_v3 = 1'b0;
   logic [31:0] held_e2 = '0, held_e3 = '0;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   nios2_mul_pipe #(.DATA_W(32), .LAT(L2)) u_dut2 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .stall(stall),
      .out_valid(ov2), .out_result(res2), .busy(busy2)
   );

   nios2_mul_pipe #(.DATA_W(32), .LAT(L3)) u_dut3 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .stall(stall),
      .out_valid(ov3), .out_result(res3), .busy(busy3)
   );

   function automatic logic [31:0] hx(input logic [31:0] v);
      return HIGH ? v : 32'h0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Result is visible LAT cycles after the cycle the op was presented.
   always @(posedge clk) begin
      if (reset_n) begin
         last_stalled = stall;
         if (!stall) begin
            nse++;
            if (in_valid) begin
               q2.push_back('{val: cur_exp, due: nse + L2 - 1});
               q3.push_back('{val: cur_exp, due: nse + L3 - 1});
            end
         end
      end
   end

   always @(negedge clk) begin
      if (reset_n) begin
         if (last_stalled) begin
            chk("hold2_valid", {31'b0, ov2}, {31'b0, held_v2});
            if (held_v2) chk("hold2_result", res2, held_e2);
         end else begin
            held_v2 = 1'b0;
            if (ov2) begin
               if (q2.size() == 0) begin
                  chk("spurious2", {31'b0, ov2}, 32'h0);
               end else begin
                  e2 = q2.pop_front();
                  chk("result2", res2, e2.val);
                  chk("latency2", nse, e2.due);
                  held_v2 = 1'b1;
                  held_e2 = e2.val;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (reset_n) begin
         if (last_stalled) begin
            chk("hold3_valid", {31'b0, ov3}, {31'b0, held_v3});
            if (held_v3) chk("hold3_result", res3, held_e3);
         end else begin
            held_v3 = 1'b0;
            if (ov3) begin
               if (q3.size() == 0) begin
                  chk("spurious3", {31'b0, ov3}, 32'h0);
               end else begin
                  e3 = q3.pop_front();
                  chk("result3", res3, e3.val);
                  chk("latency3", nse, e3.due);
                  held_v3 = 1'b1;
                  held_e3 = e3.val;
               end
            end
         end
      end
   end

   task automatic issue(input mul_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e);
      @(negedge clk);
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      cur_exp  = e;
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 30 && (q2.size() != 0 || q3.size() != 0); i++) @(negedge clk);
      chk("drain2", q2.size(), 32'd0);
      chk("drain3", q3.size(), 32'd0);
      @(negedge clk);
      @(negedge clk);
      chk("idle_busy2", {31'b0, busy2}, 32'd0);
      chk("idle_busy3", {31'b0, busy3}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #1;
      chk("rst_valid2", {31'b0, ov2}, 32'd0);
      chk("rst_result2", res2, 32'd0);
      chk("rst_busy2", {31'b0, busy2}, 32'd0);
      chk("rst_valid3", {31'b0, ov3}, 32'd0);
      chk("rst_busy3", {31'b0, busy3}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      issue(MUL_OP_MUL, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F);
      idle();
      chk("busy2_inflight", {31'b0, busy2}, 32'd1);
      chk("busy3_inflight", {31'b0, busy3}, 32'd1);
      drain();

      issue(MUL_OP_MULXUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, hx(32'hFFFF_FFFE));
      issue(MUL_OP_MULXSS, 32'hFFFF_FFFF, 32'hFFFF_FFFF, hx(32'h0000_0000));
      issue(MUL_OP_MULXSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, hx(32'hFFFF_FFFF));
      issue(MUL_OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
      idle();
      drain();

      issue(MUL_OP_MUL, 32'd1,          32'd1,          32'd1);
      issue(MUL_OP_MUL, 32'd2,          32'd3,          32'd6);
      issue(MUL_OP_MUL, 32'd7,          32'd7,          32'd49);
      issue(MUL_OP_MUL, 32'h0001_0000,  32'h0001_0000,  32'd0);
      idle();
      drain();

      issue(MUL_OP_MULXUU, 32'h8000_0000, 32'd4,          hx(32'h0000_0002));
      issue(MUL_OP_MULXSS, 32'h8000_0000, 32'd2,          hx(32'hFFFF_FFFF));
      issue(MUL_OP_MULXSU, 32'd2,         32'h8000_0000,  hx(32'h0000_0001));
      issue(MUL_OP_MULXSS, 32'd3,         32'hFFFF_FFFE,  hx(32'hFFFF_FFFF));
      issue(MUL_OP_MULXSU, 32'd3,         32'hFFFF_FFFE,  hx(32'h0000_0002));
      idle();
      drain();

      // Two ops in flight, then a 3-cycle stall with an op offered that must not be taken.
      issue(MUL_OP_MUL, 32'd5,         32'd7,   32'd35);
      issue(MUL_OP_MUL, 32'h1234_5678, 32'h10,  32'h2345_6780);
      @(negedge clk);
      stall    = 1'b1;
      in_valid = 1'b1;
      in_op    = MUL_OP_MUL;
      in_a     = 32'd9;
      in_b     = 32'd9;
      cur_exp  = 32'd81;
      repeat (3) @(negedge clk);
      stall    = 1'b0;
      in_valid = 1'b0;
      drain();

      issue(MUL_OP_MUL, 32'd11, 32'd13, 32'd143);
      issue(MUL_OP_MUL, 32'd17, 32'd19, 32'd323);
      idle();
      #2;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_valid2", {31'b0, ov2}, 32'd0);
      chk("mid_rst_busy2", {31'b0, busy2}, 32'd0);
      chk("mid_rst_valid3", {31'b0, ov3}, 32'd0);
      chk("mid_rst_busy3", {31'b0, busy3}, 32'd0);
      q2.delete();
      q3.delete();
      held_v2 = 1'b0;
      held_v3 = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);

      issue(MUL_OP_MULXUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, hx(32'hFFFF_FFFE));
      issue(MUL_OP_MUL,    32'd5,         32'd7,         32'd35);
      idle();
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule
